fetch_ctrl: RTL and testbench

//  Sequences the IF stage of the pipelined LEGv8 core against a variable-latency

---
 rtl/fetch_ctrl.sv | 137 +++++++++++++
 tb/tb_fetch_ctrl.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: owns the PC, issues one imem request at a time,
// registers the returned word toward decode and squashes on redirect.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   PCSrc_F, PCBranch_F        redirect request and its target
//   stall_D                    decode cannot accept this cycle
//   imem_req, imem_addr_F      request to instruction memory
//   imem_ack, imem_rdata       response from instruction memory
//   instr_valid_F, instr_F,    registered instruction, its PC,
//   instr_pc_F                 and its valid flag toward decode
module fetch_ctrl #(
  parameter int             N        = 64,
  parameter logic [N-1:0]   RESET_PC = '0,
  parameter int             INC      = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          PCSrc_F,
  input  logic [N-1:0]  PCBranch_F,
  input  logic          stall_D,
  output logic          imem_req,
  output logic [N-1:0]  imem_addr_F,
  input  logic          imem_ack,
  input  logic [31:0]   imem_rdata,
  output logic          instr_valid_F,
  output logic [31:0]   instr_F,
  output logic [N-1:0]  instr_pc_F
);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    HOLD,
    FLUSH
  } state_t;

  state_t       state_q;
  state_t       state_n;
  logic [N-1:0] pc_q;
  logic [N-1:0] pc_n;
  logic [N-1:0] addr_q;
  logic [N-1:0] addr_n;
  logic         valid_q;
  logic         valid_n;
  logic [31:0]  instr_q;
  logic [31:0]  instr_n;
  logic [N-1:0] ipc_q;
  logic [N-1:0] ipc_n;
  logic [N-1:0] pc_inc;

  // Wraps modulo 2^N by construction.
  assign pc_inc = pc_q + N'(INC);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      addr_q  <= RESET_PC;
      valid_q <= 1'b0;
      instr_q <= '0;
      ipc_q   <= '0;
    end else begin
      state_q <= state_n;
      pc_q    <= pc_n;
      addr_q  <= addr_n;
      valid_q <= valid_n;
      instr_q <= instr_n;
      ipc_q   <= ipc_n;
    end
  end

  always_comb begin
    state_n = state_q;
    pc_n    = pc_q;
    addr_n  = addr_q;
    valid_n = valid_q;
    instr_n = instr_q;
    ipc_n   = ipc_q;
    unique case (state_q)
      IDLE: begin
        state_n = REQ;
        addr_n  = pc_q;
      end
      REQ: begin
        if (PCSrc_F) begin
          pc_n    = PCBranch_F;
          valid_n = 1'b0;
          // Without an ack the old request is still owed, so the
          // address must stay put until memory answers it.
          if (imem_ack) begin
            addr_n = PCBranch_F;
          end else begin
            state_n = FLUSH;
          end
        end else if (imem_ack) begin
          instr_n = imem_rdata;
          ipc_n   = addr_q;
          valid_n = 1'b1;
          pc_n    = pc_inc;
          state_n = HOLD;
        end
      end
      HOLD: begin
        if (PCSrc_F) begin
          valid_n = 1'b0;
          pc_n    = PCBranch_F;
          addr_n  = PCBranch_F;
          state_n = REQ;
        end else if (!stall_D) begin
          valid_n = 1'b0;
          addr_n  = pc_q;
          state_n = REQ;
        end
      end
      FLUSH: begin
        if (PCSrc_F) begin
          pc_n = PCBranch_F;
        end
        if (imem_ack) begin
          addr_n  = PCSrc_F ? PCBranch_F : pc_q;
          state_n = REQ;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  assign imem_req      = (state_q == REQ) || (state_q == FLUSH);
  assign imem_addr_F   = addr_q;
  assign instr_valid_F = valid_q;
  assign instr_F       = instr_q;
  assign instr_pc_F    = ipc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: a cycle table of inputs and
// expected post-edge outputs, plus a hand-written redirect sequence.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        pcsrc;
  logic [63:0] br;
  logic        stall;
  logic        req;
  logic [63:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic        vld;
  logic [31:0] ins;
  logic [63:0] ipc;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  fetch_ctrl dut (
    .clk           (clk),
    .reset         (reset),
    .PCSrc_F       (pcsrc),
    .PCBranch_F    (br),
    .stall_D       (stall),
    .imem_req      (req),
    .imem_addr_F   (addr),
    .imem_ack      (ack),
    .imem_rdata    (rdata),
    .instr_valid_F (vld),
    .instr_F       (ins),
    .instr_pc_F    (ipc)
  );

  typedef struct {
    logic        rst;
    logic        src;
    logic [63:0] br;
    logic        stl;
    logic        ack;
    logic [31:0] rd;
    logic        e_req;
    logic [63:0] e_addr;
    logic        e_vld;
    logic [31:0] e_ins;
    logic [63:0] e_ipc;
  } vec_t;

  vec_t tbl[$];

  localparam logic [63:0] TOP = 64'hFFFF_FFFF_FFFF_FFFC;

  function automatic logic [31:0] w(input logic [63:0] a);
    return {16'hD000, a[15:0]};
  endfunction

  function automatic vec_t mk(
    input logic rst, input logic src,
    input logic [63:0] b, input logic stl,
    input logic ak, input logic [31:0] rd,
    input logic e_req, input logic [63:0] e_addr,
    input logic e_vld, input logic [31:0] e_ins,
    input logic [63:0] e_ipc);
    vec_t v;
    v.rst = rst; v.src = src; v.br = b;
    v.stl = stl; v.ack = ak; v.rd = rd;
    v.e_req = e_req; v.e_addr = e_addr;
    v.e_vld = e_vld; v.e_ins = e_ins;
    v.e_ipc = e_ipc;
    return v;
  endfunction

  task automatic chk(input string nm, input int idx,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s[%0d]: got %h want %h",
               nm, idx, act, exp);
    end
  endtask

  task automatic step(input logic r, input logic s,
                      input logic [63:0] b, input logic st,
                      input logic ak, input logic [31:0] rd);
    reset = r; pcsrc = s; br = b;
    stall = st; ack = ak; rdata = rd;
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; pcsrc = 1'b0; br = '0;
    stall = 1'b0; ack = 1'b0; rdata = '0;

    // reset, then zero-wait fetch of 0,4,8,12
    tbl.push_back(mk(1,0,0,0,0,0,      0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,w(0),   0,0,1,w(0),0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,4,0,w(0),0));
    tbl.push_back(mk(0,0,0,0,1,w(4),   0,4,1,w(4),4));
    tbl.push_back(mk(0,0,0,0,0,0,      1,8,0,w(4),4));
    tbl.push_back(mk(0,0,0,0,1,w(8),   0,8,1,w(8),8));
    tbl.push_back(mk(0,0,0,0,0,0,      1,12,0,w(8),8));
    tbl.push_back(mk(0,0,0,0,1,w(12),  0,12,1,w(12),12));
    // decode stall held for four cycles
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0,0,0,1,0,0,    0,12,1,w(12),12));
    tbl.push_back(mk(0,0,0,0,0,0,      1,16,0,w(12),12));
    // three-cycle memory wait
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0,0,0,0,0,0,    1,16,0,w(12),12));
    tbl.push_back(mk(0,0,0,0,1,w(16),  0,16,1,w(16),16));
    tbl.push_back(mk(0,0,0,0,0,0,      1,20,0,w(16),16));
    // redirect while request pending -> flush
    tbl.push_back(mk(0,1,'h100,0,0,0,  1,20,0,w(16),16));
    tbl.push_back(mk(0,0,0,0,0,0,      1,20,0,w(16),16));
    tbl.push_back(mk(0,0,0,0,1,32'hBAD00014,
                                       1,'h100,0,w(16),16));
    tbl.push_back(mk(0,0,0,0,1,w('h100),
                                       0,'h100,1,w('h100),'h100));
    // redirect in HOLD (wins over stall)
    tbl.push_back(mk(0,1,'h200,1,0,0,  1,'h200,0,w('h100),'h100));
    // redirect with ack in the same cycle
    tbl.push_back(mk(0,1,'h300,0,1,32'hBAD00200,
                                       1,'h300,0,w('h100),'h100));
    tbl.push_back(mk(0,0,0,0,1,w('h300),
                                       0,'h300,1,w('h300),'h300));
    tbl.push_back(mk(0,0,0,0,0,0,      1,'h304,0,w('h300),'h300));
    // repeated redirects in FLUSH: latest wins
    tbl.push_back(mk(0,1,'h400,0,0,0,  1,'h304,0,w('h300),'h300));
    tbl.push_back(mk(0,1,'h500,0,0,0,  1,'h304,0,w('h300),'h300));
    tbl.push_back(mk(0,1,'h600,0,1,32'hBAD00304,
                                       1,'h600,0,w('h300),'h300));
    tbl.push_back(mk(0,0,0,0,0,0,      1,'h600,0,w('h300),'h300));
    // reset during REQ; late ack in IDLE ignored
    tbl.push_back(mk(1,0,0,0,1,32'hBAD00600,
                                       0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'hBAD00000,
                                       1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,w(0),   0,0,1,w(0),0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,4,0,w(0),0));
    // reset during FLUSH, beating a redirect and an ack
    tbl.push_back(mk(0,1,'h800,0,0,0,  1,4,0,w(0),0));
    tbl.push_back(mk(1,1,'h900,0,1,32'hBAD00004,
                                       0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'hBAD00008,
                                       1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,      1,0,0,0,0));
    // PC wrap at the top of the address space
    tbl.push_back(mk(0,1,TOP,0,0,0,    1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,32'hBAD0000C,
                                       1,TOP,0,0,0));
    tbl.push_back(mk(0,0,0,0,1,w(TOP), 0,TOP,1,w(TOP),TOP));
    tbl.push_back(mk(0,0,0,0,0,0,      1,0,0,w(TOP),TOP));

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].src, tbl[i].br,
           tbl[i].stl, tbl[i].ack, tbl[i].rd);
      chk("req",   i, 64'(req),  64'(tbl[i].e_req));
      chk("addr",  i, addr,      tbl[i].e_addr);
      chk("vld",   i, 64'(vld),  64'(tbl[i].e_vld));
      chk("instr", i, 64'(ins),  64'(tbl[i].e_ins));
      chk("ipc",   i, ipc,       tbl[i].e_ipc);
    end

    // Redirect to 0x100 while the request at 0x8 is pending;
    // the word at 0x8 must never appear as valid.
    step(1,0,0,0,0,0);
    step(0,0,0,0,0,0);
    step(0,0,0,0,1,w(0));
    step(0,0,0,0,0,0);
    step(0,0,0,0,1,w(4));
    step(0,0,0,0,0,0);
    chk("s_addr8", 0, addr, 64'h8);
    step(0,1,'h100,0,0,0);
    chk("s_flreq", 0, 64'(req), 64'h1);
    chk("s_fladdr", 0, addr, 64'h8);
    chk("s_flvld", 0, 64'(vld), 64'h0);
    step(0,0,0,0,0,0);
    chk("s_fladdr", 1, addr, 64'h8);
    chk("s_flvld", 1, 64'(vld), 64'h0);
    step(0,0,0,0,1,w(8));
    chk("s_newaddr", 0, addr, 64'h100);
    chk("s_newvld", 0, 64'(vld), 64'h0);
    begin
      int n;
      n = 0;
      while (!vld && n < 10) begin
        step(0,0,0,0,1,w(addr));
        n++;
      end
      if (n >= 10) begin
        n_chk++;
        n_fail++;
        $display("FAIL s_timeout: no valid after %0d cycles", n);
      end else begin
        chk("s_ipc", 0, ipc, 64'h100);
        chk("s_ins", 0, 64'(ins), 64'(w('h100)));
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
